// File: rtl/phys_free_list_pkg.sv
// Shared sizing for the physical-register free list.
// P_REG_SIZE : number of physical registers (power of two, > 32)
// P_WIDTH    : physical index width
// FL_DEPTH   : free-list capacity (registers beyond the 32 architectural ones)
// FL_PTR_W   : ring pointer width including the wrap bit
package phys_free_list_pkg;

    localparam int unsigned P_REG_SIZE = 64;
    localparam int unsigned P_WIDTH    = $clog2(P_REG_SIZE);
    localparam int unsigned FL_DEPTH   = P_REG_SIZE - 32;
    localparam int unsigned FL_PTR_W   = $clog2(FL_DEPTH) + 1;
    localparam int unsigned FL_IDX_W   = FL_PTR_W - 1;

    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [P_WIDTH-1:0]  paddr_t;

endpackage

// File: rtl/fl_ring_ptr.sv
// Wrap-bit ring pointer with increment and load.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (to RstVal)
//   inc_i       : advance pointer by one
//   load_i      : load load_val_i (takes priority over inc_i)
//   load_val_i  : value to load
//   ptr_o       : registered pointer value
module fl_ring_ptr
    import phys_free_list_pkg::*;
#(
    parameter fl_ptr_t RstVal = '0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    inc_i,
    input  logic    load_i,
    input  fl_ptr_t load_val_i,
    output fl_ptr_t ptr_o
);

    fl_ptr_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + fl_ptr_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= RstVal;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for the rename stage.
// Rename allocates from the speculative head; the ROB returns old mappings at the tail.
// A committed head lets a flush restore every speculative allocation in one cycle.
// Optional feature: define FREELIST_DUP_CHECK_EN to track a per-register free bit and
// flag (sticky dup_err) pushes of already-free registers or pushes into a full list.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   alloc_req         : rename wants one destination register
//   alloc_ready       : list non-empty, allocation accepted this cycle
//   alloc_paddr       : index at head (show-ahead)
//   commit_valid      : ROB commits one instruction with rd != x0
//   commit_old_paddr  : old mapping returned to the list
//   flush             : discard all uncommitted allocations
//   free_count        : number of free entries
//   dup_err           : sticky duplicate-free error (0 without FREELIST_DUP_CHECK_EN)
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output logic                alloc_ready,
    output logic [P_WIDTH-1:0]  alloc_paddr,
    input  logic                commit_valid,
    input  logic [P_WIDTH-1:0]  commit_old_paddr,
    input  logic                flush,
    output logic [FL_PTR_W-1:0] free_count,
    output logic                dup_err
);

    fl_ptr_t head_q, commit_head_q, tail_q;
    fl_ptr_t commit_head_next;
    paddr_t  mem_q [FL_DEPTH];

    logic fire, full, push_req, push;

    assign free_count       = tail_q - head_q;
    assign alloc_ready      = (free_count != '0);
    assign alloc_paddr      = mem_q[head_q[FL_IDX_W-1:0]];
    assign fire             = alloc_req & alloc_ready & ~flush;
    assign full             = (free_count == fl_ptr_t'(FL_DEPTH));
    // x0 never has a physical mapping to return
    assign push_req         = commit_valid & (commit_old_paddr != '0);
    assign commit_head_next = commit_head_q + fl_ptr_t'(commit_valid);

    fl_ring_ptr #(.RstVal(fl_ptr_t'(0))) u_head (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (fire),
        .load_i     (flush),
        .load_val_i (commit_head_next),
        .ptr_o      (head_q)
    );

    fl_ring_ptr #(.RstVal(fl_ptr_t'(0))) u_commit_head (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (commit_valid),
        .load_i     (1'b0),
        .load_val_i (fl_ptr_t'(0)),
        .ptr_o      (commit_head_q)
    );

    // Starts with the wrap bit set: tail - head = FL_DEPTH, list full
    fl_ring_ptr #(.RstVal(fl_ptr_t'(FL_DEPTH))) u_tail (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (push),
        .load_i     (1'b0),
        .load_val_i (fl_ptr_t'(0)),
        .ptr_o      (tail_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= paddr_t'(32 + i);
            end
        end else if (push) begin
            mem_q[tail_q[FL_IDX_W-1:0]] <= commit_old_paddr;
        end
    end

`ifdef FREELIST_DUP_CHECK_EN
    logic [P_REG_SIZE-1:0] is_free_q, is_free_d;
    logic                  dup_err_q, dup_hit;
    fl_ptr_t               tail_next, live_cnt;

    assign dup_hit   = push_req & (full | is_free_q[commit_old_paddr]);
    assign push      = push_req & ~dup_hit;
    assign tail_next = tail_q + fl_ptr_t'(push);
    assign live_cnt  = tail_next - commit_head_next;

    always_comb begin
        is_free_d = is_free_q;
        if (flush) begin
            // Rebuild from the committed window [commit_head_next, tail_next),
            // using this cycle's push value for the slot being written.
            is_free_d = '0;
            for (int i = 0; i < FL_DEPTH; i++) begin
                if ({1'b0, FL_IDX_W'(i) - commit_head_next[FL_IDX_W-1:0]} < live_cnt) begin
                    if (push && (FL_IDX_W'(i) == tail_q[FL_IDX_W-1:0])) begin
                        is_free_d[commit_old_paddr] = 1'b1;
                    end else begin
                        is_free_d[mem_q[i]] = 1'b1;
                    end
                end
            end
        end else begin
            if (fire) begin
                is_free_d[alloc_paddr] = 1'b0;
            end
            if (push) begin
                is_free_d[commit_old_paddr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_free_q <= {{FL_DEPTH{1'b1}}, {(P_REG_SIZE - FL_DEPTH){1'b0}}};
            dup_err_q <= 1'b0;
        end else begin
            is_free_q <= is_free_d;
            if (dup_hit) begin
                dup_err_q <= 1'b1;
            end
        end
    end

    assign dup_err = dup_err_q;
`else
    assign push    = push_req & ~full;
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                alloc_req = 1'b0;
    logic                alloc_ready;
    logic [P_WIDTH-1:0]  alloc_paddr;
    logic                commit_valid = 1'b0;
    logic [P_WIDTH-1:0]  commit_old_paddr = '0;
    logic                flush = 1'b0;
    logic [FL_PTR_W-1:0] free_count;
    logic                dup_err;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    typedef struct {
        bit alloc;
        bit cv;
        int pa;
        bit fl;
        bit rdy;
        int exp_pa;
        int exp_cnt;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req        (alloc_req),
        .alloc_ready      (alloc_ready),
        .alloc_paddr      (alloc_paddr),
        .commit_valid     (commit_valid),
        .commit_old_paddr (commit_old_paddr),
        .flush            (flush),
        .free_count       (free_count),
        .dup_err          (dup_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        alloc_req = 0; commit_valid = 0; flush = 0; commit_old_paddr = '0;
        rst = 1;
        #2;
        rst = 0;
        #1;
    endtask

    // Drive one cycle of inputs, return #1 after the active edge
    task automatic cycle(input bit a, input bit cv, input int pa, input bit fl);
        alloc_req = a; commit_valid = cv; commit_old_paddr = P_WIDTH'(pa); flush = fl;
        @(posedge clk);
        #1;
        alloc_req = 0; commit_valid = 0; commit_old_paddr = '0; flush = 0;
    endtask

    initial begin
        // Table: {alloc, commit, paddr, flush, exp ready, exp paddr, exp count}
        vecs[0]  = '{1, 0, 0,  0, 1, 33, 31};
        vecs[1]  = '{1, 0, 0,  0, 1, 34, 30};
        vecs[2]  = '{1, 0, 0,  0, 1, 35, 29};
        vecs[3]  = '{0, 1, 7,  0, 1, 35, 30};
        vecs[4]  = '{0, 0, 0,  1, 1, 33, 32};
        vecs[5]  = '{1, 0, 0,  0, 1, 34, 31};
        vecs[6]  = '{1, 1, 9,  0, 1, 35, 31};
        vecs[7]  = '{1, 1, 11, 1, 1, 35, 32};
        vecs[8]  = '{1, 0, 0,  0, 1, 36, 31};
        vecs[9]  = '{0, 0, 0,  1, 1, 35, 32};
        vecs[10] = '{0, 0, 0,  0, 1, 35, 32};

        // Reset state
        do_reset();
        check("reset_ready", int'(alloc_ready), 1);
        check("reset_paddr", int'(alloc_paddr), 32);
        check("reset_count", int'(free_count), FL_DEPTH);
        check("reset_dup", int'(dup_err), 0);

        // Allocate / commit / flush table
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].alloc, vecs[i].cv, vecs[i].pa, vecs[i].fl);
            check($sformatf("vec%0d_ready", i), int'(alloc_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d_paddr", i), int'(alloc_paddr), vecs[i].exp_pa);
            check($sformatf("vec%0d_count", i), int'(free_count), vecs[i].exp_cnt);
            check($sformatf("vec%0d_dup", i), int'(dup_err), 0);
        end

        // Drain the whole list; scoreboard holds the expected FIFO contents
        do_reset();
        exp_q.delete();
        for (int i = 0; i < FL_DEPTH; i++) exp_q.push_back(32 + i);
        for (int i = 0; i < FL_DEPTH; i++) begin
            check($sformatf("drain%0d_ready", i), int'(alloc_ready), 1);
            check($sformatf("drain%0d_paddr", i), int'(alloc_paddr), exp_q.pop_front());
            cycle(1, 0, 0, 0);
        end
        check("empty_ready", int'(alloc_ready), 0);
        check("empty_count", int'(free_count), 0);

        // Commit into an empty list: same-cycle request is not granted
        cycle(1, 1, 5, 0);
        exp_q.push_back(5);
        check("refill_ready", int'(alloc_ready), 1);
        check("refill_paddr", int'(alloc_paddr), exp_q[0]);
        check("refill_count", int'(free_count), 1);

        // Streaming alloc + commit every cycle; returned indices reappear in order
        for (int i = 0; i < 100; i++) begin
            int v;
            v = 10 + (i % 50);
            check($sformatf("stream%0d_paddr", i), int'(alloc_paddr), exp_q.pop_front());
            exp_q.push_back(v);
            cycle(1, 1, v, 0);
            check($sformatf("stream%0d_count", i), int'(free_count), 1);
        end
        check("stream_dup", int'(dup_err), 0);

        // Zero and overflow pushes are dropped
        do_reset();
        cycle(0, 1, 0, 0);
        check("zero_push_count", int'(free_count), FL_DEPTH);
        check("zero_push_dup", int'(dup_err), 0);
        cycle(0, 1, 20, 0);
        check("full_push_count", int'(free_count), FL_DEPTH);
        check("full_push_paddr", int'(alloc_paddr), 32);
`ifdef FREELIST_DUP_CHECK_EN
        check("full_push_dup", int'(dup_err), 1);
`else
        check("full_push_dup", int'(dup_err), 0);
`endif

        // Returning a register that is still free
        do_reset();
        check("dup_after_rst", int'(dup_err), 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 40, 0);
`ifdef FREELIST_DUP_CHECK_EN
        check("dup_free_count", int'(free_count), FL_DEPTH - 1);
        check("dup_free_flag", int'(dup_err), 1);
`else
        check("dup_free_count", int'(free_count), FL_DEPTH);
        check("dup_free_flag", int'(dup_err), 0);
`endif
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
`ifdef FREELIST_DUP_CHECK_EN
        check("dup_sticky", int'(dup_err), 1);
`else
        check("dup_sticky", int'(dup_err), 0);
`endif
        do_reset();
        check("dup_cleared", int'(dup_err), 0);
        check("final_count", int'(free_count), FL_DEPTH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
